// File: rtl/answer_checker_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | answer_checker_if                                                     |
// | Player inputs, timer handshake and round outputs of the checker.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface answer_checker_if;
  logic       btn;
  logic [7:0] sw;
  logic       numGen;
  logic [3:0] level;
  logic [7:0] target;
  logic       submit;
  logic       correct;
  logic       wrong;
  logic [7:0] score;

  modport master (
    output btn, sw, numGen, level,
    input  target, submit, correct, wrong, score
  );

  modport slave (
    input  btn, sw, numGen, level,
    output target, submit, correct, wrong, score
  );
endinterface
`default_nettype wire

// File: rtl/answer_checker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | answer_checker                                                        |
// | Round controller: LFSR target, button debounce, answer compare and    |
// | submit/correct handshake back to the countdown timer.                 |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module answer_checker #(
  parameter int          DEBOUNCE_CYCLES = 1_000_000,
  parameter int          WRONG_CYCLES    = 50_000_000,
  parameter logic [15:0] SEED            = 16'hACE1
) (
  input  wire logic       clk,
  input  wire logic       reset,
  answer_checker_if.slave bus
);

  localparam int c_db_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_wc_w = (WRONG_CYCLES > 1) ? $clog2(WRONG_CYCLES) : 1;
  localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_wc_w-1:0] c_wc_last = c_wc_w'(WRONG_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_PLAY  = 2'd1,
    S_HOLD  = 2'd2,
    S_WRONG = 2'd3
  } state_t;

  logic              btn_meta_q, btn_s_q, btn_db_q, btn_db_prev_q;
  logic              ng_meta_q, ng_s_q, ng_d_q;
  logic [c_db_w-1:0] db_cnt_q;

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [7:0]        target_q, target_d;
  logic              submit_q, submit_d;
  logic              correct_q, correct_d;
  logic              wrong_q, wrong_d;
  logic [7:0]        score_q, score_d;
  logic [c_wc_w-1:0] wcnt_q, wcnt_d;

  logic              w_press, w_ng_rise, w_fb;
  logic [15:0]       w_lfsr_next;

  // Input synchronizers and button debouncer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta_q    <= 1'b0;
      btn_s_q       <= 1'b0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      ng_meta_q     <= 1'b0;
      ng_s_q        <= 1'b0;
      ng_d_q        <= 1'b0;
      db_cnt_q      <= '0;
    end else begin
      btn_meta_q    <= bus.btn;
      btn_s_q       <= btn_meta_q;
      btn_db_prev_q <= btn_db_q;
      ng_meta_q     <= bus.numGen;
      ng_s_q        <= ng_meta_q;
      ng_d_q        <= ng_s_q;
      if (btn_s_q == btn_db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == c_db_last) begin
        btn_db_q <= btn_s_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  assign w_press     = btn_db_q & ~btn_db_prev_q;
  assign w_ng_rise   = ng_s_q & ~ng_d_q;
  assign w_fb        = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign w_lfsr_next = {lfsr_q[14:0], w_fb};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_LOAD;
      lfsr_q    <= SEED;
      target_q  <= 8'd0;
      submit_q  <= 1'b0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      score_q   <= 8'd0;
      wcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      target_q  <= target_d;
      submit_q  <= submit_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      score_q   <= score_d;
      wcnt_q    <= wcnt_d;
    end
  end

  // ng_rise is checked first in every state so a coincident press is dropped
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    target_d  = target_q;
    submit_d  = submit_q;
    correct_d = correct_q;
    wrong_d   = wrong_q;
    score_d   = score_q;
    wcnt_d    = wcnt_q;
    case (state_q)
      S_LOAD: begin
        lfsr_d    = w_lfsr_next;
        target_d  = (bus.level <= 4'd5) ? {4'b0000, w_lfsr_next[3:0]}
                                        : w_lfsr_next[7:0];
        submit_d  = 1'b0;
        correct_d = 1'b0;
        wrong_d   = 1'b0;
        state_d   = S_PLAY;
      end
      S_PLAY: begin
        if (w_ng_rise) begin
          state_d = S_LOAD;
        end else if (w_press) begin
          if (bus.sw == target_q) begin
            submit_d  = 1'b1;
            correct_d = 1'b1;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
            state_d   = S_HOLD;
          end else begin
            wrong_d = 1'b1;
            wcnt_d  = '0;
            state_d = S_WRONG;
          end
        end
      end
      S_HOLD: begin
        if (w_ng_rise) begin
          submit_d  = 1'b0;
          correct_d = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_WRONG: begin
        if (w_ng_rise) begin
          wrong_d = 1'b0;
          state_d = S_LOAD;
        end else if (wcnt_q == c_wc_last) begin
          wrong_d = 1'b0;
          state_d = S_PLAY;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign bus.target  = target_q;
  assign bus.submit  = submit_q;
  assign bus.correct = correct_q;
  assign bus.wrong   = wrong_q;
  assign bus.score   = score_q;

endmodule
`default_nettype wire

// File: tb/tb_answer_checker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_answer_checker                                                     |
// | Directed self-checking bench for answer_checker.                      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_answer_checker;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  answer_checker_if u_if ();

  answer_checker #(
    .DEBOUNCE_CYCLES (4),
    .WRONG_CYCLES    (8),
    .SEED            (16'hACE1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; u_if.btn = 1'b0; u_if.sw = 8'h00; u_if.numGen = 1'b0; u_if.level = 4'd1;
    step(2);
    n_checks++; if (u_if.target !== 8'h00) $display("FAIL rst_target: got %0h exp 0", u_if.target); else n_pass++;
    n_checks++; if (u_if.submit !== 1'b0) $display("FAIL rst_submit: got %0b exp 0", u_if.submit); else n_pass++;
    n_checks++; if (u_if.correct !== 1'b0) $display("FAIL rst_correct: got %0b exp 0", u_if.correct); else n_pass++;
    n_checks++; if (u_if.wrong !== 1'b0) $display("FAIL rst_wrong: got %0b exp 0", u_if.wrong); else n_pass++;
    n_checks++; if (u_if.score !== 8'h00) $display("FAIL rst_score: got %0h exp 0", u_if.score); else n_pass++;
    reset = 1'b0;
    step(1);
    n_checks++; if (dut.lfsr_q !== 16'h59C3) $display("FAIL first_lfsr: got %0h exp 59c3", dut.lfsr_q); else n_pass++;
    n_checks++; if (u_if.target !== 8'h03) $display("FAIL first_target: got %0h exp 3", u_if.target); else n_pass++;
    n_checks++; if (u_if.submit !== 1'b0 || u_if.correct !== 1'b0 || u_if.wrong !== 1'b0)
      $display("FAIL first_flags: got s%0b c%0b w%0b exp 000", u_if.submit, u_if.correct, u_if.wrong); else n_pass++;
  endtask

  task automatic test_correct();
    u_if.sw = 8'h03; u_if.btn = 1'b1;
    step(6);
    n_checks++; if (u_if.submit !== 1'b0) $display("FAIL ok_early_submit: got %0b exp 0", u_if.submit); else n_pass++;
    step(1);
    n_checks++; if (u_if.submit !== 1'b1) $display("FAIL ok_submit: got %0b exp 1", u_if.submit); else n_pass++;
    n_checks++; if (u_if.correct !== 1'b1) $display("FAIL ok_correct: got %0b exp 1", u_if.correct); else n_pass++;
    n_checks++; if (u_if.score !== 8'd1) $display("FAIL ok_score: got %0d exp 1", u_if.score); else n_pass++;
    step(3);
    u_if.btn = 1'b0;
    step(8);
    n_checks++; if (u_if.submit !== 1'b1 || u_if.correct !== 1'b1)
      $display("FAIL ok_hold: got s%0b c%0b exp 11", u_if.submit, u_if.correct); else n_pass++;
    n_checks++; if (u_if.score !== 8'd1) $display("FAIL ok_held_score: got %0d exp 1", u_if.score); else n_pass++;
    u_if.numGen = 1'b1;
    step(3);
    n_checks++; if (u_if.submit !== 1'b0 || u_if.correct !== 1'b0)
      $display("FAIL ok_release: got s%0b c%0b exp 00", u_if.submit, u_if.correct); else n_pass++;
    n_checks++; if (u_if.target !== 8'h03) $display("FAIL ok_target_early: got %0h exp 3", u_if.target); else n_pass++;
    step(1);
    n_checks++; if (u_if.target !== 8'h07) $display("FAIL ok_target_new: got %0h exp 7", u_if.target); else n_pass++;
    u_if.numGen = 1'b0;
    step(2);
  endtask

  task automatic test_wrong();
    u_if.sw = 8'h13; u_if.btn = 1'b1;
    step(6);
    n_checks++; if (u_if.wrong !== 1'b0) $display("FAIL bad_early_wrong: got %0b exp 0", u_if.wrong); else n_pass++;
    step(1);
    n_checks++; if (u_if.wrong !== 1'b1) $display("FAIL bad_wrong: got %0b exp 1", u_if.wrong); else n_pass++;
    n_checks++; if (u_if.score !== 8'd1) $display("FAIL bad_score: got %0d exp 1", u_if.score); else n_pass++;
    for (int i = 0; i < 7; i++) begin
      step(1);
      n_checks++; if (u_if.wrong !== 1'b1 || u_if.submit !== 1'b0)
        $display("FAIL bad_window_%0d: got w%0b s%0b exp w1 s0", i, u_if.wrong, u_if.submit); else n_pass++;
    end
    step(1);
    n_checks++; if (u_if.wrong !== 1'b0) $display("FAIL bad_end: got %0b exp 0", u_if.wrong); else n_pass++;
    n_checks++; if (u_if.score !== 8'd1 || u_if.submit !== 1'b0)
      $display("FAIL bad_after: got score %0d s%0b exp 1 s0", u_if.score, u_if.submit); else n_pass++;
    u_if.btn = 1'b0;
    step(8);
    // back in PLAY: a correct answer must now be accepted
    u_if.sw = 8'h07; u_if.btn = 1'b1;
    step(7);
    n_checks++; if (u_if.submit !== 1'b1 || u_if.score !== 8'd2)
      $display("FAIL bad_replay: got s%0b score %0d exp s1 score 2", u_if.submit, u_if.score); else n_pass++;
    u_if.btn = 1'b0;
    step(8);
  endtask

  task automatic test_timeout();
    u_if.level = 4'd6; u_if.numGen = 1'b1;
    step(3);
    n_checks++; if (u_if.submit !== 1'b0 || u_if.correct !== 1'b0)
      $display("FAIL to_clear: got s%0b c%0b exp 00", u_if.submit, u_if.correct); else n_pass++;
    step(1);
    n_checks++; if (u_if.target !== 8'h0F) $display("FAIL to_target_l6a: got %0h exp f", u_if.target); else n_pass++;
    step(16);
    n_checks++; if (u_if.target !== 8'h0F) $display("FAIL to_held_numgen: got %0h exp f", u_if.target); else n_pass++;
    u_if.numGen = 1'b0;
    step(2);
    u_if.numGen = 1'b1;
    step(4);
    n_checks++; if (u_if.target !== 8'h1E) $display("FAIL to_target_l6b: got %0h exp 1e", u_if.target); else n_pass++;
    u_if.numGen = 1'b0; u_if.level = 4'd1;
    step(2);
    u_if.numGen = 1'b1;
    step(4);
    n_checks++; if (u_if.target !== 8'h0C) $display("FAIL to_target_l1: got %0h exp c", u_if.target); else n_pass++;
    n_checks++; if (u_if.score !== 8'd2) $display("FAIL to_score: got %0d exp 2", u_if.score); else n_pass++;
    u_if.numGen = 1'b0;
    step(2);
  endtask

  task automatic test_bounce();
    u_if.sw = 8'h0C; u_if.btn = 1'b1;
    step(2);
    u_if.btn = 1'b0;
    step(10);
    n_checks++; if (u_if.submit !== 1'b0 || u_if.wrong !== 1'b0 || u_if.score !== 8'd2)
      $display("FAIL glitch: got s%0b w%0b score %0d exp s0 w0 score 2", u_if.submit, u_if.wrong, u_if.score); else n_pass++;
    // numGen raised so its rising edge lands on the same cycle as the press
    u_if.btn = 1'b1;
    step(4);
    u_if.numGen = 1'b1;
    step(3);
    n_checks++; if (u_if.submit !== 1'b0 || u_if.correct !== 1'b0 || u_if.score !== 8'd2)
      $display("FAIL collide: got s%0b c%0b score %0d exp s0 c0 score 2", u_if.submit, u_if.correct, u_if.score); else n_pass++;
    step(1);
    n_checks++; if (u_if.target !== 8'h09) $display("FAIL collide_target: got %0h exp 9", u_if.target); else n_pass++;
    step(5);
    n_checks++; if (u_if.submit !== 1'b0 || u_if.score !== 8'd2)
      $display("FAIL collide_after: got s%0b score %0d exp s0 score 2", u_if.submit, u_if.score); else n_pass++;
    u_if.btn = 1'b0; u_if.numGen = 1'b0;
    step(8);
  endtask

  task automatic test_hold_reset();
    u_if.sw = 8'h09; u_if.btn = 1'b1;
    step(7);
    n_checks++; if (u_if.submit !== 1'b1 || u_if.correct !== 1'b1 || u_if.score !== 8'd3)
      $display("FAIL hr_hold: got s%0b c%0b score %0d exp s1 c1 score 3", u_if.submit, u_if.correct, u_if.score); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (u_if.submit !== 1'b0 || u_if.correct !== 1'b0)
      $display("FAIL hr_async: got s%0b c%0b exp 00", u_if.submit, u_if.correct); else n_pass++;
    n_checks++; if (u_if.score !== 8'd0 || u_if.target !== 8'h00)
      $display("FAIL hr_async_regs: got score %0d target %0h exp 0 0", u_if.score, u_if.target); else n_pass++;
    step(1);
    u_if.btn = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
    n_checks++; if (u_if.target !== 8'h03) $display("FAIL hr_target: got %0h exp 3", u_if.target); else n_pass++;
    n_checks++; if (u_if.score !== 8'd0 || u_if.submit !== 1'b0)
      $display("FAIL hr_after: got score %0d s%0b exp 0 s0", u_if.score, u_if.submit); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_correct();
    test_wrong();
    test_timeout();
    test_bounce();
    test_hold_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/answer_checker.md
# answer_checker

Round controller for the decimal-to-binary game: generates the decimal target, debounces the submit button, compares the switch value against the target, and drives `submit`/`correct` back to the level/LED countdown timer. It consumes the timer's `numGen` and `level` outputs and is the other end of the timer's `submit`/`correct` ↔ `numGen` interface. It sits beside the timer in the top level and feeds `target` to the seven-segment display path.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive `clk` cycles the button must be stable before the debounced level changes.
- `WRONG_CYCLES`, default 50_000_000: number of cycles `wrong` stays asserted after a bad answer.
- `SEED`, default 16'hACE1: LFSR reset value. Must be nonzero.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `btn`  in  1  raw submit push-button; asynchronous and bouncy.
- `sw`  in  8  player's binary answer.
- `numGen`  in  1  new-round request from the timer; slow domain, so it is synchronized here.
- `level`  in  4  current level from the timer, 1–10.
- `target`  out  8  current decimal target.
- `submit`  out  1  answer-submitted flag to the timer.
- `correct`  out  1  answer-matches flag to the timer.
- `wrong`  out  1  bad-answer indicator for the LEDs.
- `score`  out  8  count of correct rounds; saturates at 255.

## Operation
- **Synchronizers.** `btn` and `numGen` each pass through 2 flops to give `btn_s` and `ng_s`.
  - `ng_rise` = `ng_s` & ~`ng_d`, where `ng_d` is `ng_s` delayed one cycle. It is a single-cycle pulse.
- **Debounce.** A counter runs while `btn_s` != `btn_db`.
  - When the counter reaches DEBOUNCE_CYCLES−1, `btn_db` takes `btn_s` and the counter clears.
  - Any cycle with `btn_s` == `btn_db` clears the counter.
  - `press` = rising edge of `btn_db`, one cycle wide.
- **LFSR.** 16-bit Fibonacci: `fb` = b15^b13^b12^b10, next = {lfsr[14:0], fb}. It advances only in LOAD.
- **Target masking** uses the new LFSR value:
  - `level` ≤ 5: `target` = {4'b0, next[3:0]}, range 0–15.
  - Otherwise: `target` = next[7:0], range 0–255.
- **Compare.** Full 8-bit equality `sw` == `target`. On low levels, nonzero `sw[7:4]` is therefore wrong.
- **FSM:**
  - LOAD: advance the LFSR, load `target`, go to PLAY. Lasts exactly 1 cycle.
  - PLAY:
    - `ng_rise` → LOAD. This is a timeout: no score change.
    - Else `press` with a match → HOLD: `submit`=1, `correct`=1, `score`+1 (saturating).
    - Else `press` with a mismatch → WRONG: `wrong`=1, wrong counter cleared.
  - HOLD:
    - `submit`/`correct` stay high so the slow timer is guaranteed to sample them.
    - `ng_rise` → LOAD; `submit` and `correct` clear on that transition.
  - WRONG:
    - `wrong` stays high until the counter reaches WRONG_CYCLES−1 → PLAY with `wrong`=0.
    - `ng_rise` → LOAD with `wrong`=0.
    - Presses in this state are ignored.
- **Priority:** `ng_rise` beats `press` in the same cycle; that press is discarded.
- Presses in LOAD or HOLD are ignored.
- `level` is sampled only in LOAD. The timer updates `level` in the same slow edge that raises `numGen`, so the new level is always used.

## Timing
- **Reset (async):**
  - Outputs: `target`=0, `submit`=0, `correct`=0, `wrong`=0, `score`=0.
  - Internals: LFSR=SEED, all synchronizers/counters/`btn_db` 0, state=LOAD.
- **First cycle after reset release** is LOAD, so `target` is valid after the 1st `clk` edge.
- **`numGen` → `target` latency.** Counted from the first edge at which `numGen`=1 is sampled:
  - `ng_s` is high after 2 edges; `ng_rise` is seen in that cycle.
  - State is LOAD after the 3rd edge; `target` updates at the 4th edge.
- **Button latency.** `btn` press → `press` pulse occurs 2 (sync) + DEBOUNCE_CYCLES edges after `btn` goes high, provided it stays stable.
- **`press` → outputs.** `submit`/`correct`/`wrong`/`score` change at the edge that consumes `press` (1 cycle).
- **Button held.** Only one `press` per debounced rising edge. Holding the button never re-submits.
- **Reset mid-HOLD or mid-WRONG:** outputs drop immediately, asynchronously.
- **`numGen` held high** for many `clk` cycles produces exactly one `ng_rise`.

## Test plan
Bench settings: DEBOUNCE_CYCLES=4, WRONG_CYCLES=8, SEED=16'hACE1, `level`=1.
- **Reset then release** → LFSR=16'h59C3 and `target`=3 one edge after release; `submit`=`correct`=`wrong`=0, `score`=0.
- **Correct answer.** `sw`=3, hold `btn` for 10 cycles → `submit`=`correct`=1 at edge 2+4+1 after the press, `score`=1. Both stay high until `numGen` is pulsed; `target` changes 4 edges after `numGen` is seen high, and `submit`/`correct` are 0 by then.
- **Wrong answer.** `sw`=8'h13 (upper bits set) at `level` 1, press → `wrong`=1 for exactly 8 cycles, then PLAY. `score` unchanged, `submit`=0 throughout.
- **Timeout.** `numGen` pulse with no press → new `target` and `score` unchanged. With `level`=6 before the pulse, `target` is an 8-bit value, and it is ≤15 when `level` ≤ 5.
- **Bounce and collision.**
  - A `btn` glitch of 2 cycles produces no press.
  - A press whose `press` pulse coincides with `ng_rise` → LOAD taken, press dropped, `score` unchanged.
- **Async reset mid-HOLD** → `submit`/`correct` go to 0 immediately. After release, `target`=3 again and `score`=0.
